// File: rtl/matrix_frame_overlay_pkg.sv
// Shared constants and geometry helpers for the matrix bracket overlay and the
// VGA timing generator it sits beside.
package matrix_frame_overlay_pkg;

  localparam int DEFAULT_COORD_W = 12;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_TOTAL  = 800;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_TOTAL  = 525;

  typedef enum logic {
    BLINK_OFF = 1'b0,
    BLINK_ON  = 1'b1
  } blink_phase_e;

  function automatic int bracket_height(input int rows, input int cell_h, input int pad);
    return rows * cell_h + 2 * pad;
  endfunction

  function automatic int bracket_sep(input int cols, input int cell_w, input int pad);
    return cols * cell_w + 2 * pad;
  endfunction

endpackage

// File: rtl/matrix_frame_overlay_bracket_shape.sv
// Combinational point-in-bracket test: '[' when MIRROR=0, ']' when MIRROR=1.
module bracket_shape #(
  parameter bit MIRROR = 1'b0,
  parameter int CW     = 14
) (
  input  logic [CW-1:0] px,
  input  logic [CW-1:0] py,
  input  logic [CW-1:0] ox,
  input  logic [CW-1:0] oy,
  input  logic [CW-1:0] height,
  input  logic [CW-1:0] width,
  input  logic [CW-1:0] thick,
  output logic          hit
);

  logic in_box;
  logic cut_y;
  logic cut_x;

  assign in_box = (px >= ox) && (px < ox + width) && (py >= oy) && (py < oy + height);
  assign cut_y  = (py >= oy + thick) && (py < oy + height - thick);

  // The cutout opens toward the cells, so the mirrored bracket keeps its stroke on the right.
  if (MIRROR) begin : g_right
    assign cut_x = (px < ox + width - thick);
  end else begin : g_left
    assign cut_x = (px >= ox + thick);
  end

  assign hit = in_box && !(cut_y && cut_x);

endmodule

// File: rtl/matrix_frame_overlay.sv
// Two-stage pipelined overlay drawing matrix brackets and a blinking highlighted
// cell outline, with a frame-synchronised movable position.
module matrix_frame_overlay
  import matrix_frame_overlay_pkg::*;
#(
  parameter int ROWS           = 3,
  parameter int COLS           = 3,
  parameter int CELL_W         = 52,
  parameter int CELL_H         = 34,
  parameter int PAD            = 2,
  parameter int LINE_THICKNESS = 2,
  parameter int BRACKET_WIDTH  = 4,
  parameter int X0_INIT        = 100,
  parameter int Y0_INIT        = 50,
  parameter int COORD_W        = DEFAULT_COORD_W,
  parameter int BLINK_FRAMES   = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               frame_start,
  input  logic               pos_valid,
  output logic               pos_ready,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic               hl_en,
  input  logic [7:0]         hl_row,
  input  logic [7:0]         hl_col,
  output logic               pixel_on,
  output logic               hl_on
);

  localparam int CW = COORD_W + 2;
  localparam logic [CW-1:0] H_C        = CW'(bracket_height(ROWS, CELL_H, PAD));
  localparam logic [CW-1:0] SEP_C      = CW'(bracket_sep(COLS, CELL_W, PAD));
  localparam logic [CW-1:0] BW_C       = CW'(BRACKET_WIDTH);
  localparam logic [CW-1:0] LT_C       = CW'(LINE_THICKNESS);
  localparam logic [CW-1:0] PAD_C      = CW'(PAD);
  localparam logic [CW-1:0] CELL_W_C   = CW'(CELL_W);
  localparam logic [CW-1:0] CELL_H_C   = CW'(CELL_H);
  localparam logic [CW-1:0] CELL_W_M1  = CW'(CELL_W - 1);
  localparam logic [CW-1:0] CELL_H_M1  = CW'(CELL_H - 1);
  localparam logic [7:0]    ROWS_C     = 8'(ROWS);
  localparam logic [7:0]    COLS_C     = 8'(COLS);
  localparam int            FCW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(BLINK_FRAMES - 1);

  logic [COORD_W-1:0] active_x, active_y;
  logic [COORD_W-1:0] pend_x, pend_y;
  logic               pending_valid;
  logic [FCW-1:0]     frame_cnt;
  blink_phase_e       blink_phase;

  assign pos_ready = !pending_valid;

  // A new position waits in the pending slot so it only lands on a frame boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_x      <= COORD_W'(X0_INIT);
      active_y      <= COORD_W'(Y0_INIT);
      pend_x        <= '0;
      pend_y        <= '0;
      pending_valid <= 1'b0;
    end else if (frame_start && pending_valid) begin
      active_x      <= pend_x;
      active_y      <= pend_y;
      pending_valid <= 1'b0;
    end else if (pos_valid && !pending_valid) begin
      pend_x        <= pos_x;
      pend_y        <= pos_y;
      pending_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= BLINK_ON;
    end else if (frame_start) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= (blink_phase == BLINK_ON) ? BLINK_OFF : BLINK_ON;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  logic [CW-1:0] px, py, x0_w, y0_w, rx_w, cell_x, cell_y;
  logic          left_hit, right_hit, hl_sel;

  assign px     = CW'(x);
  assign py     = CW'(y);
  assign x0_w   = CW'(active_x);
  assign y0_w   = CW'(active_y);
  assign rx_w   = x0_w + BW_C + SEP_C;
  assign cell_x = x0_w + BW_C + PAD_C + CW'(hl_col) * CELL_W_C;
  assign cell_y = y0_w + PAD_C + CW'(hl_row) * CELL_H_C;
  assign hl_sel = hl_en && (hl_row < ROWS_C) && (hl_col < COLS_C) && (blink_phase == BLINK_ON);

  bracket_shape #(.MIRROR(1'b0), .CW(CW)) u_left (
    .px(px), .py(py), .ox(x0_w), .oy(y0_w),
    .height(H_C), .width(BW_C), .thick(LT_C), .hit(left_hit)
  );

  bracket_shape #(.MIRROR(1'b1), .CW(CW)) u_right (
    .px(px), .py(py), .ox(rx_w), .oy(y0_w),
    .height(H_C), .width(BW_C), .thick(LT_C), .hit(right_hit)
  );

  logic [CW-1:0] s1_x, s1_y, s1_cx, s1_cy;
  logic          s1_left, s1_right, s1_hl;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_x     <= '0;
      s1_y     <= '0;
      s1_cx    <= '0;
      s1_cy    <= '0;
      s1_left  <= 1'b0;
      s1_right <= 1'b0;
      s1_hl    <= 1'b0;
    end else begin
      s1_x     <= px;
      s1_y     <= py;
      s1_cx    <= cell_x;
      s1_cy    <= cell_y;
      s1_left  <= left_hit;
      s1_right <= right_hit;
      s1_hl    <= hl_sel;
    end
  end

  logic [CW-1:0] cx_end, cy_end;
  logic          in_cell, on_edge;

  assign cx_end  = s1_cx + CELL_W_M1;
  assign cy_end  = s1_cy + CELL_H_M1;
  assign in_cell = (s1_x >= s1_cx) && (s1_x <= cx_end) && (s1_y >= s1_cy) && (s1_y <= cy_end);
  assign on_edge = (s1_x == s1_cx) || (s1_x == cx_end) || (s1_y == s1_cy) || (s1_y == cy_end);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixel_on <= 1'b0;
      hl_on    <= 1'b0;
    end else begin
      pixel_on <= s1_left || s1_right;
      hl_on    <= s1_hl && in_cell && on_edge;
    end
  end

endmodule

// File: tb/tb_matrix_frame_overlay.sv
// Directed-vector bench for matrix_frame_overlay with default geometry
// (X0=100, Y0=50, H=106, SEP=160, right bracket at X0+4+160=264).
module tb_matrix_frame_overlay;

  logic        clk;
  logic        rst_n;
  logic [11:0] x, y;
  logic        frame_start;
  logic        pos_valid;
  logic        pos_ready;
  logic [11:0] pos_x, pos_y;
  logic        hl_en;
  logic [7:0]  hl_row, hl_col;
  logic        pixel_on;
  logic        hl_on;

  int checks = 0;
  int passed = 0;

  matrix_frame_overlay dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .frame_start(frame_start),
    .pos_valid(pos_valid), .pos_ready(pos_ready), .pos_x(pos_x), .pos_y(pos_y),
    .hl_en(hl_en), .hl_row(hl_row), .hl_col(hl_col),
    .pixel_on(pixel_on), .hl_on(hl_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic pulse_frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      tick;
      frame_start = 1'b0;
      tick;
    end
  endtask

  // Presents one pixel and returns the outputs two clocks later.
  task automatic probe(input int px, input int py, output logic p, output logic h);
    x = 12'(px);
    y = 12'(py);
    tick;
    tick;
    p = pixel_on;
    h = hl_on;
  endtask

  task automatic test_reset;
    x = 12'd100;
    y = 12'd60;
    rst_n = 1'b0;
    tick;
    tick;
    checks++; if (pos_ready !== 1'b1) $display("[TB] FAIL rst_ready: got %b want 1", pos_ready); else passed++;
    checks++; if (pixel_on !== 1'b0) $display("[TB] FAIL rst_pixel: got %b want 0", pixel_on); else passed++;
    checks++; if (hl_on !== 1'b0) $display("[TB] FAIL rst_hl: got %b want 0", hl_on); else passed++;
    rst_n = 1'b1;
    tick;
    checks++; if (pixel_on !== 1'b0) $display("[TB] FAIL rst_release_c1: got %b want 0", pixel_on); else passed++;
    tick;
    checks++; if (pixel_on !== 1'b1) $display("[TB] FAIL rst_release_c2: got %b want 1", pixel_on); else passed++;
  endtask

  task automatic test_back_to_back;
    int  bx [11] = '{100, 102, 102, 103, 267, 264, 264, 268,  99, 100, 150};
    int  by [11] = '{ 60,  60,  50, 155, 100, 100, 155, 100,  60, 156, 100};
    bit  be [11] = '{  1,   0,   1,   1,   1,   0,   1,   0,   0,   0,   0};
    do_reset;
    for (int i = 0; i <= 11; i++) begin
      if (i < 11) begin
        x = 12'(bx[i]);
        y = 12'(by[i]);
      end
      tick;
      if (i >= 1) begin
        checks++;
        if (pixel_on !== be[i-1])
          $display("[TB] FAIL bracket_%0d_%0d: got %b want %b", bx[i-1], by[i-1], pixel_on, be[i-1]);
        else passed++;
      end
    end
  endtask

  task automatic test_handshake;
    logic p, h;
    do_reset;
    pos_x = 12'd200;
    pos_y = 12'd50;
    pos_valid = 1'b1;
    #1;
    checks++; if (pos_ready !== 1'b1) $display("[TB] FAIL hs_ready_idle: got %b want 1", pos_ready); else passed++;
    tick;
    checks++; if (pos_ready !== 1'b0) $display("[TB] FAIL hs_ready_pending: got %b want 0", pos_ready); else passed++;
    pos_x = 12'd300;
    probe(100, 60, p, h);
    checks++; if (p !== 1'b1) $display("[TB] FAIL hs_old_pos: got %b want 1", p); else passed++;
    checks++; if (pos_ready !== 1'b0) $display("[TB] FAIL hs_second_offer_held: got %b want 0", pos_ready); else passed++;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    checks++; if (pos_ready !== 1'b1) $display("[TB] FAIL hs_ready_after_frame: got %b want 1", pos_ready); else passed++;
    tick;
    pos_valid = 1'b0;
    checks++; if (pos_ready !== 1'b0) $display("[TB] FAIL hs_second_accepted: got %b want 0", pos_ready); else passed++;
    probe(100, 60, p, h);
    checks++; if (p !== 1'b0) $display("[TB] FAIL hs_old_gone: got %b want 0", p); else passed++;
    probe(200, 60, p, h);
    checks++; if (p !== 1'b1) $display("[TB] FAIL hs_new_pos: got %b want 1", p); else passed++;
    pulse_frames(1);
    probe(300, 60, p, h);
    checks++; if (p !== 1'b1) $display("[TB] FAIL hs_second_pos: got %b want 1", p); else passed++;
    probe(200, 60, p, h);
    checks++; if (p !== 1'b0) $display("[TB] FAIL hs_second_old_gone: got %b want 0", p); else passed++;
  endtask

  task automatic test_highlight;
    int hx [7] = '{210, 230, 230, 261, 262, 209, 230};
    int hy [7] = '{100,  86, 100, 119, 100, 100, 120};
    bit he [7] = '{  1,   1,   0,   1,   0,   0,   0};
    logic p, h;
    do_reset;
    hl_en  = 1'b1;
    hl_row = 8'd1;
    hl_col = 8'd2;
    for (int i = 0; i < 7; i++) begin
      probe(hx[i], hy[i], p, h);
      checks++;
      if (h !== he[i]) $display("[TB] FAIL hl_%0d_%0d: got %b want %b", hx[i], hy[i], h, he[i]);
      else passed++;
    end
    hl_en = 1'b0;
    probe(210, 100, p, h);
    checks++; if (h !== 1'b0) $display("[TB] FAIL hl_disabled: got %b want 0", h); else passed++;
    hl_en  = 1'b1;
    hl_row = 8'd3;
    probe(210, 154, p, h);
    checks++; if (h !== 1'b0) $display("[TB] FAIL hl_row_oob: got %b want 0", h); else passed++;
    hl_row = 8'd1;
    hl_col = 8'd3;
    probe(262, 86, p, h);
    checks++; if (h !== 1'b0) $display("[TB] FAIL hl_col_oob: got %b want 0", h); else passed++;
    hl_col = 8'd2;
  endtask

  task automatic test_blink;
    int   steps [5] = '{0, 29, 1, 29, 1};
    bit   want  [5] = '{1,  1, 0,  0, 1};
    int   seen = 0;
    logic p, h;
    do_reset;
    hl_en  = 1'b1;
    hl_row = 8'd1;
    hl_col = 8'd2;
    for (int i = 0; i < 5; i++) begin
      pulse_frames(steps[i]);
      seen += steps[i];
      probe(210, 100, p, h);
      checks++;
      if (h !== want[i]) $display("[TB] FAIL blink_after_%0d_frames: got %b want %b", seen, h, want[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid;
    logic p, h;
    do_reset;
    hl_en  = 1'b1;
    hl_row = 8'd1;
    hl_col = 8'd2;
    pulse_frames(30);
    probe(210, 100, p, h);
    checks++; if (h !== 1'b0) $display("[TB] FAIL mid_phase_off: got %b want 0", h); else passed++;
    pos_x = 12'd300;
    pos_y = 12'd70;
    pos_valid = 1'b1;
    tick;
    pos_valid = 1'b0;
    checks++; if (pos_ready !== 1'b0) $display("[TB] FAIL mid_pending: got %b want 0", pos_ready); else passed++;
    x = 12'd100;
    y = 12'd60;
    rst_n = 1'b0;
    frame_start = 1'b1;
    tick;
    checks++; if (pos_ready !== 1'b1) $display("[TB] FAIL mid_ready: got %b want 1", pos_ready); else passed++;
    tick;
    rst_n = 1'b1;
    frame_start = 1'b0;
    checks++; if (pixel_on !== 1'b0) $display("[TB] FAIL mid_out_c0: got %b want 0", pixel_on); else passed++;
    tick;
    checks++; if (pixel_on !== 1'b0) $display("[TB] FAIL mid_out_c1: got %b want 0", pixel_on); else passed++;
    tick;
    checks++; if (pixel_on !== 1'b1) $display("[TB] FAIL mid_pos_restored: got %b want 1", pixel_on); else passed++;
    probe(210, 100, p, h);
    checks++; if (h !== 1'b1) $display("[TB] FAIL mid_phase_on: got %b want 1", h); else passed++;
    pulse_frames(1);
    probe(300, 75, p, h);
    checks++; if (p !== 1'b0) $display("[TB] FAIL mid_pending_dropped: got %b want 0", p); else passed++;
    probe(100, 60, p, h);
    checks++; if (p !== 1'b1) $display("[TB] FAIL mid_pos_kept: got %b want 1", p); else passed++;
  endtask

  task automatic test_same_cycle;
    logic p, h;
    do_reset;
    pos_x = 12'd150;
    pos_y = 12'd50;
    pos_valid = 1'b1;
    frame_start = 1'b1;
    tick;
    pos_valid = 1'b0;
    frame_start = 1'b0;
    checks++; if (pos_ready !== 1'b0) $display("[TB] FAIL same_pending: got %b want 0", pos_ready); else passed++;
    probe(100, 60, p, h);
    checks++; if (p !== 1'b1) $display("[TB] FAIL same_unchanged: got %b want 1", p); else passed++;
    pulse_frames(1);
    probe(150, 60, p, h);
    checks++; if (p !== 1'b1) $display("[TB] FAIL same_applied: got %b want 1", p); else passed++;
    probe(100, 60, p, h);
    checks++; if (p !== 1'b0) $display("[TB] FAIL same_old_gone: got %b want 0", p); else passed++;
  endtask

  initial begin
    rst_n       = 1'b0;
    x           = '0;
    y           = '0;
    frame_start = 1'b0;
    pos_valid   = 1'b0;
    pos_x       = '0;
    pos_y       = '0;
    hl_en       = 1'b0;
    hl_row      = '0;
    hl_col      = '0;
    test_reset;
    test_back_to_back;
    test_handshake;
    test_highlight;
    test_blink;
    test_reset_mid;
    test_same_cycle;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
